// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: FSM state encoding, scoring defaults,
// datapath widths and screen geometry used by the game loop.
package pong_pkg;

  // Datapath widths
  localparam int unsigned SCORE_W = 5;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned HOLD_W  = 8;

  // Match defaults
  localparam int unsigned WIN_SCORE_DEF   = 11;
  localparam int unsigned HOLD_FRAMES_DEF = 60;

  // Screen geometry consumed by the ball/paddle loop
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned BORDER_W = 10;

  // Match sequencer states; values double as the debug LED code
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_t;

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational 5-bit binary to two-digit BCD converter for score display.
// Ports:
//   i_bin  : binary value 0..31
//   o_tens : tens digit 0..3
//   o_ones : ones digit 0..9
module bin_to_bcd
  import pong_pkg::*;
(
  input  logic [SCORE_W-1:0] i_bin,
  output logic [DIGIT_W-1:0] o_tens,
  output logic [DIGIT_W-1:0] o_ones
);

  // Range compare is cheaper than a divider for a 0..31 input
  always_comb begin
    o_tens = 4'd0;
    o_ones = 4'(i_bin);
    if (i_bin >= 5'd30) begin
      o_tens = 4'd3;
      o_ones = 4'(i_bin - 5'd30);
    end else if (i_bin >= 5'd20) begin
      o_tens = 4'd2;
      o_ones = 4'(i_bin - 5'd20);
    end else if (i_bin >= 5'd10) begin
      o_tens = 4'd1;
      o_ones = 4'(i_bin - 5'd10);
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Match scoring stage: turns border-hit levels into point events, keeps both
// scores and sequences serve -> play -> point-hold -> match-over.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   frame_tick        : one-cycle per-frame strobe (hold countdown)
//   launch, new_game  : serve request / match restart levels
//   left_hit/right_hit: border crossing levels (point to P2 / P1)
//   p1/p2_score       : binary scores, p*_tens/p*_ones BCD digits
//   play_en, hold, game_over, state_code : state decodes
//   serve_dir, point_pulse, winner       : point / match results
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               launch,
  input  logic               new_game,
  input  logic               left_hit,
  input  logic               right_hit,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [DIGIT_W-1:0] p1_tens,
  output logic [DIGIT_W-1:0] p1_ones,
  output logic [DIGIT_W-1:0] p2_tens,
  output logic [DIGIT_W-1:0] p2_ones,
  output logic               play_en,
  output logic               hold,
  output logic               serve_dir,
  output logic               point_pulse,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state_code
);

  state_t               r_state, w_state;
  logic [SCORE_W-1:0]   r_p1, w_p1, r_p2, w_p2;
  logic [HOLD_W-1:0]    r_cnt, w_cnt;
  logic                 r_pulse, w_pulse;
  logic                 r_dir, w_dir;
  logic                 r_winner, w_winner;
  logic                 r_left_q, r_right_q;

  logic                 w_left_ev, w_right_ev;
  logic [SCORE_W-1:0]   w_p1_inc, w_p2_inc;

  // Rising-edge events; hit_q tracks the level in every state so a level
  // already high when PLAY is entered never registers as an event
  assign w_left_ev  = left_hit  & ~r_left_q;
  assign w_right_ev = right_hit & ~r_right_q;
  assign w_p1_inc   = r_p1 + 5'd1;
  assign w_p2_inc   = r_p2 + 5'd1;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_p1      <= '0;
      r_p2      <= '0;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_dir     <= 1'b0;
      r_winner  <= 1'b0;
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_p1      <= w_p1;
      r_p2      <= w_p2;
      r_cnt     <= w_cnt;
      r_pulse   <= w_pulse;
      r_dir     <= w_dir;
      r_winner  <= w_winner;
      r_left_q  <= left_hit;
      r_right_q <= right_hit;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state  = r_state;
    w_p1     = r_p1;
    w_p2     = r_p2;
    w_cnt    = r_cnt;
    w_pulse  = 1'b0;
    w_dir    = r_dir;
    w_winner = r_winner;

    if (new_game) begin
      w_state  = ST_IDLE;
      w_p1     = '0;
      w_p2     = '0;
      w_cnt    = '0;
      w_dir    = 1'b0;
      w_winner = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (launch) w_state = ST_PLAY;
        end
        ST_PLAY: begin
          // Simultaneous events cancel: both are consumed, nothing scores
          if (w_left_ev ^ w_right_ev) begin
            w_pulse = 1'b1;
            if (w_right_ev) begin
              w_p1  = w_p1_inc;
              w_dir = 1'b1;
              if (w_p1_inc == 5'(WIN_SCORE)) begin
                w_state  = ST_OVER;
                w_winner = 1'b0;
              end else begin
                w_state = ST_HOLD;
                w_cnt   = 8'(HOLD_FRAMES);
              end
            end else begin
              w_p2  = w_p2_inc;
              w_dir = 1'b0;
              if (w_p2_inc == 5'(WIN_SCORE)) begin
                w_state  = ST_OVER;
                w_winner = 1'b1;
              end else begin
                w_state = ST_HOLD;
                w_cnt   = 8'(HOLD_FRAMES);
              end
            end
          end
        end
        ST_HOLD: begin
          // <= 1 also guards an impossible zero count from wrapping
          if (frame_tick) begin
            if (r_cnt <= 8'd1) begin
              w_state = ST_IDLE;
              w_cnt   = '0;
            end else begin
              w_cnt = r_cnt - 8'd1;
            end
          end
        end
        ST_OVER: begin
          w_state = ST_OVER;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  bin_to_bcd u_p1_bcd (
    .i_bin  (r_p1),
    .o_tens (p1_tens),
    .o_ones (p1_ones)
  );

  bin_to_bcd u_p2_bcd (
    .i_bin  (r_p2),
    .o_tens (p2_tens),
    .o_ones (p2_ones)
  );

  assign p1_score    = r_p1;
  assign p2_score    = r_p2;
  assign point_pulse = r_pulse;
  assign serve_dir   = r_dir;
  assign winner      = r_winner;
  assign play_en     = (r_state == ST_PLAY);
  assign hold        = (r_state == ST_HOLD);
  assign game_over   = (r_state == ST_OVER);
  assign state_code  = 2'(r_state);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural match model.
module tb_score_keeper;

  localparam int unsigned WIN = 11;
  localparam int unsigned HF  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       launch = 1'b0;
  logic       new_game = 1'b0;
  logic       left_hit = 1'b0;
  logic       right_hit = 1'b0;
  logic [4:0] p1_score, p2_score;
  logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
  logic       play_en, hold, serve_dir, point_pulse, game_over, winner;
  logic [1:0] state_code;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase 0 idle, 1 play, 2 hold, 3 over
  int m_phase = 0;
  int m_p1 = 0, m_p2 = 0, m_frames_left = 0;
  int m_pulse = 0, m_dir = 0, m_winner = 0;
  int m_lprev = 0, m_rprev = 0;

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(WIN), .HOLD_FRAMES(HF)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .launch     (launch),
    .new_game   (new_game),
    .left_hit   (left_hit),
    .right_hit  (right_hit),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .p1_tens    (p1_tens),
    .p1_ones    (p1_ones),
    .p2_tens    (p2_tens),
    .p2_ones    (p2_ones),
    .play_en    (play_en),
    .hold       (hold),
    .serve_dir  (serve_dir),
    .point_pulse(point_pulse),
    .game_over  (game_over),
    .winner     (winner),
    .state_code (state_code)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Award one point; who==1 means P1 scored
  task automatic award(input int who);
    int s;
    m_pulse = 1;
    if (who == 1) begin m_p1++; s = m_p1; m_dir = 1; end
    else          begin m_p2++; s = m_p2; m_dir = 0; end
    if (s == int'(WIN)) begin
      m_phase  = 3;
      m_winner = (who == 1) ? 0 : 1;
    end else begin
      m_phase = 2;
      m_frames_left = int'(HF);
    end
  endtask

  task automatic ref_step();
    bit lev, rev;
    lev = left_hit && (m_lprev == 0);
    rev = right_hit && (m_rprev == 0);
    m_lprev = int'(left_hit);
    m_rprev = int'(right_hit);
    m_pulse = 0;
    if (reset) begin
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_frames_left = 0;
      m_dir = 0; m_winner = 0; m_lprev = 0; m_rprev = 0;
    end else if (new_game) begin
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_frames_left = 0;
      m_dir = 0; m_winner = 0;
    end else if (m_phase == 0) begin
      if (launch) m_phase = 1;
    end else if (m_phase == 1) begin
      if (rev && !lev) award(1);
      else if (lev && !rev) award(2);
    end else if (m_phase == 2) begin
      if (frame_tick) begin
        m_frames_left--;
        if (m_frames_left == 0) m_phase = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("p1_score",   p1_score,    m_p1);
    check("p2_score",   p2_score,    m_p2);
    check("p1_tens",    p1_tens,     m_p1 / 10);
    check("p1_ones",    p1_ones,     m_p1 % 10);
    check("p2_tens",    p2_tens,     m_p2 / 10);
    check("p2_ones",    p2_ones,     m_p2 % 10);
    check("state_code", state_code,  m_phase);
    check("play_en",    play_en,     m_phase == 1);
    check("hold",       hold,        m_phase == 2);
    check("game_over",  game_over,   m_phase == 3);
    check("point_pulse", point_pulse, m_pulse);
    check("serve_dir",  serve_dir,   m_dir);
    if (m_phase == 3) check("winner", winner, m_winner);
  endtask

  // One clock: model advances on the same edge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    ref_step();
    #1;
    compare_all();
  endtask

  task automatic frame_once();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
  endtask

  initial begin
    int pulses;

    // Reset
    reset = 1'b1;
    tick(); tick();
    check("rst_p1",    p1_score,   0);
    check("rst_p2",    p2_score,   0);
    check("rst_state", state_code, 0);
    check("rst_play",  play_en,    0);
    check("rst_over",  game_over,  0);
    check("rst_dir",   serve_dir,  0);
    reset = 1'b0;
    tick();

    // Single point with a held right_hit level
    launch = 1'b1; tick(); launch = 1'b0;
    check("launch_play", state_code, 1);
    right_hit = 1'b1;
    pulses = 0;
    repeat (10) begin tick(); pulses += int'(point_pulse); end
    right_hit = 1'b0;
    check("pt_pulses", pulses,     1);
    check("pt_p1",     p1_score,   1);
    check("pt_dir",    serve_dir,  1);
    check("pt_state",  state_code, 2);
    frame_once(); frame_once();
    check("hold_2of3", state_code, 2);
    frame_once();
    check("hold_done", state_code, 0);
    launch = 1'b1; tick(); launch = 1'b0;
    check("relaunch", state_code, 1);

    // Simultaneous events cancel
    left_hit = 1'b1; right_hit = 1'b1; tick();
    check("sim_p1",    p1_score,    1);
    check("sim_p2",    p2_score,    0);
    check("sim_pulse", point_pulse, 0);
    check("sim_state", state_code,  1);
    tick();
    check("sim_held", state_code, 1);
    left_hit = 1'b0; right_hit = 1'b0; tick();

    // Stale level through IDLE and launch
    new_game = 1'b1; left_hit = 1'b1; tick(); new_game = 1'b0;
    check("ng_state", state_code, 0);
    check("ng_p1",    p1_score,   0);
    tick(); tick();
    launch = 1'b1; tick(); launch = 1'b0;
    repeat (4) tick();
    check("stale_p2",    p2_score,   0);
    check("stale_state", state_code, 1);
    left_hit = 1'b0; tick(); left_hit = 1'b1; tick();
    check("fresh_p2",    p2_score,    1);
    check("fresh_pulse", point_pulse, 1);
    check("fresh_dir",   serve_dir,   0);
    check("fresh_state", state_code,  2);
    left_hit = 1'b0;

    // Reset mid-HOLD
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("mid_hold", state_code, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rh_state", state_code, 0);
    check("rh_p2",    p2_score,   0);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("rh_tick", state_code, 0);
    launch = 1'b1; tick(); launch = 1'b0;
    check("rh_launch", state_code, 1);

    // P2 wins the match
    new_game = 1'b1; tick(); new_game = 1'b0;
    for (int i = 0; i < int'(WIN); i++) begin
      launch = 1'b1; tick(); launch = 1'b0;
      left_hit = 1'b1; tick(); left_hit = 1'b0; tick();
      if (i < int'(WIN) - 1) repeat (HF) frame_once();
    end
    check("win_p2",    p2_score,  11);
    check("win_tens",  p2_tens,   1);
    check("win_ones",  p2_ones,   1);
    check("win_over",  game_over, 1);
    check("win_who",   winner,    1);
    launch = 1'b1; left_hit = 1'b1; right_hit = 1'b1;
    repeat (3) tick();
    launch = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
    tick(); right_hit = 1'b1; tick(); right_hit = 1'b0; tick();
    check("frozen_p1", p1_score,   0);
    check("frozen_p2", p2_score,   11);
    check("frozen_st", state_code, 3);
    new_game = 1'b1; tick(); new_game = 1'b0;
    check("ng2_p2",    p2_score,   0);
    check("ng2_state", state_code, 0);

    // Randomized traffic against the model
    repeat (4000) begin
      reset      = ($urandom_range(0, 999) == 0);
      new_game   = ($urandom_range(0, 599) == 0);
      launch     = ($urandom_range(0, 3) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) left_hit  = ~left_hit;
      if ($urandom_range(0, 4) == 0) right_hit = ~right_hit;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Match-scoring stage directly downstream of the ball/paddle game loop.
- Consumes the `left_hit`/`right_hit` point events and the per-frame animate tick.
- Keeps both players' scores and sequences serve → play → point-hold → match-over.
- Drives binary and BCD scores to the score-digit renderers, plus serve/hold/game-over control back to the game loop.

Parameters:
- WIN_SCORE, 11, score that ends the match; legal range 1..31.
- HOLD_FRAMES, 60, frames the ball stays frozen after a point; legal range 1..255.

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (animate strobe)
- launch  in  1  serve request, level
- new_game  in  1  clear scores and restart match, level
- left_hit  in  1  ball crossed left border, level; point to P2
- right_hit  in  1  ball crossed right border, level; point to P1
- p1_score  out  5  P1 binary score
- p2_score  out  5  P2 binary score
- p1_tens, p1_ones  out  4 each  P1 BCD digits
- p2_tens, p2_ones  out  4 each  P2 BCD digits
- play_en  out  1  high only in PLAY; ball may move
- hold  out  1  high in HOLD
- serve_dir  out  1  0 = serve rightward, 1 = serve leftward
- point_pulse  out  1  one-cycle pulse when a point is awarded
- game_over  out  1  high in OVER
- winner  out  1  0 = P1, 1 = P2; valid while game_over
- state_code  out  2  IDLE=0, PLAY=1, HOLD=2, OVER=3 (debug LEDs)

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values: state IDLE, all scores and digits 0, hold counter 0, serve_dir 0, and all of play_en, hold, point_pulse, game_over, winner at 0.
- Priority: reset > new_game > FSM.
- new_game in any state: next cycle scores = 0, state = IDLE, point_pulse = 0, serve_dir = 0.
- Hit edge detection:
  - `left_hit` and `right_hit` are registered every cycle in every state.
  - An event is `hit & ~hit_q`.
  - A level held high counts once.
  - A level already high on entry to PLAY never counts.
- IDLE: launch=1 → PLAY next cycle. Hit events are ignored.
- PLAY, single event at edge N:
  - The scorer's score increments, visible after edge N.
  - point_pulse is high for the cycle after edge N.
  - serve_dir is set to 1 if P1 scored, 0 if P2 scored.
  - If the new score == WIN_SCORE → OVER, with winner = scorer.
  - Otherwise → HOLD, with hold counter = HOLD_FRAMES.
- PLAY, both events on the same cycle: no score change, no point_pulse, state stays PLAY (events consumed).
- HOLD:
  - Counter decrements on each frame_tick.
  - On the frame_tick where the counter is 1 → IDLE, counter 0.
  - launch and hit events are ignored.
- OVER: scores frozen; launch and hits ignored. Only new_game or reset leaves.
- Score width and range:
  - Scores are 5-bit unsigned and never exceed WIN_SCORE, so no wrap.
  - BCD digits are a combinational function of the score registers, same cycle.
  - tens ∈ {0..3}, ones ∈ {0..9}.
- Output timing: play_en, hold, game_over and state_code decode the registered state, so there is no extra latency.
- Reset mid-HOLD or mid-PLAY: everything returns to reset values the next cycle; the hold counter is discarded.
- Hold counter width: 8 bits.

Decomposition:
- Shared package `pong_pkg`:
  - state encoding constants (IDLE/PLAY/HOLD/OVER);
  - WIN_SCORE and HOLD_FRAMES defaults;
  - screen geometry constants (640×480, border 10) used by the game loop.
- One sub-module `bin_to_bcd`: combinational, 5-bit binary in → tens/ones 4-bit out.
  - Instantiated twice.
  - Verified exhaustively 0..31 on its own bench.

Test Plan:
- Reset: assert reset 2 cycles → all scores/digits 0, state_code 0, play_en 0, game_over 0, serve_dir 0.
- Single point, HOLD_FRAMES=3:
  - Stimulus: launch, then right_hit held high 10 cycles.
  - Required: p1_score=1 exactly once, point_pulse high 1 cycle, serve_dir=1, state_code=2.
  - Then 3 frame_ticks → state_code=0.
  - Then launch → state_code=1.
- Match win, WIN_SCORE=11:
  - Stimulus: drive P2 to 11 points via left_hit pulses.
  - Required: p2_tens=1, p2_ones=1, game_over=1, winner=1.
  - Further launch/hits → no change.
  - new_game → scores 0, state_code=0.
- Simultaneous events: in PLAY, left_hit and right_hit rise on the same cycle → scores unchanged, no point_pulse, state stays PLAY.
- Stale level: hold left_hit high through IDLE and the launch → no point awarded in PLAY until left_hit falls and rises again, then p2_score=1.
- Reset mid-HOLD: reset after 1 of 3 frame_ticks → IDLE, scores 0. A subsequent frame_tick has no effect, and launch → PLAY.
